// File: rtl/mult_pkg.sv
// Shared definitions for the dot-product sequencer around the 16x16 sequential multiplier.
package mult_pkg;

  localparam int unsigned MULT_DW = 16;
  localparam int unsigned MULT_PW = 2 * MULT_DW;
  localparam int unsigned SEXT_W  = 64;

  typedef enum logic [2:0] {
    ST_FLUSH,
    ST_IDLE,
    ST_START,
    ST_BUSY,
    ST_OUTPUT
  } state_t;

  function automatic logic [SEXT_W-1:0] sext_product(input logic [MULT_PW-1:0] p);
    return {{(SEXT_W - MULT_PW){p[MULT_PW-1]}}, p};
  endfunction

endpackage

// File: rtl/mult_dot_ctrl_if.sv
// Operand stream, multiplier handshake and result stream of the dot-product sequencer.
interface mult_dot_ctrl_if
  import mult_pkg::*;
#(
  parameter int unsigned DW    = MULT_DW,
  parameter int unsigned PW    = MULT_PW,
  parameter int unsigned ACC_W = 40,
  parameter int unsigned LEN_W = 8
);

  logic             in_valid;
  logic             in_ready;
  logic [DW-1:0]    in_a;
  logic [DW-1:0]    in_b;
  logic             in_last;

  logic             mul_st;
  logic [DW-1:0]    mul_mtp;
  logic [DW-1:0]    mul_mtc;
  logic             mul_done;
  logic [PW-1:0]    mul_product;

  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_sum;
  logic [LEN_W-1:0] out_count;
  logic             out_ovf;

  // slave: the sequencer itself; master: the surrounding environment
  modport slave (
    input  in_valid, in_a, in_b, in_last, mul_done, mul_product, out_ready,
    output in_ready, mul_st, mul_mtp, mul_mtc, out_valid, out_sum, out_count, out_ovf
  );

  modport master (
    output in_valid, in_a, in_b, in_last, mul_done, mul_product, out_ready,
    input  in_ready, mul_st, mul_mtp, mul_mtc, out_valid, out_sum, out_count, out_ovf
  );

endinterface

// File: rtl/mult_dot_ctrl.sv
// Dot-product sequencer: feeds operand pairs to the sequential multiplier one at a time
// and accumulates the sign-extended products into a wide wrap-around accumulator.
module mult_dot_ctrl
  import mult_pkg::*;
#(
  parameter int unsigned DW           = MULT_DW,
  parameter int unsigned PW           = MULT_PW,
  parameter int unsigned ACC_W        = 40,
  parameter int unsigned LEN_W        = 8,
  parameter int unsigned FLUSH_CYCLES = 20
) (
  input  logic            clk,
  input  logic            rst,
  mult_dot_ctrl_if.slave  bus
);

  localparam int unsigned FW = $clog2(FLUSH_CYCLES + 1);

  state_t                   state, state_next;
  logic [FW-1:0]            flush_cnt;
  logic                     flush_done;

  logic                     last_r;
  logic signed [ACC_W-1:0]  acc;
  logic [LEN_W-1:0]         cnt;
  logic                     ovf;

  logic                     mul_st_r;
  logic [DW-1:0]            mtp_r, mtc_r;
  logic                     out_valid_r;
  logic [ACC_W-1:0]         out_sum_r;
  logic [LEN_W-1:0]         out_count_r;
  logic                     out_ovf_r;

  logic [SEXT_W-1:0]        prod_ext;
  logic [SEXT_W-1:0]        sum_w;
  logic [SEXT_W-ACC_W:0]    sum_hi;
  logic [ACC_W-1:0]         sum;
  logic                     add_ovf;
  logic                     cnt_sat;
  logic [LEN_W-1:0]         cnt_next;
  logic                     ovf_next;

  assign flush_done = (flush_cnt == FW'(FLUSH_CYCLES - 1));

  // The exact sum is formed at 64 bits; a signed overflow of the ACC_W-bit result is
  // equivalent to the bits above the ACC_W sign position not all matching it.
  always_comb begin
    prod_ext = sext_product(bus.mul_product);
    sum_w    = SEXT_W'(acc) + prod_ext;
    sum_hi   = sum_w[SEXT_W-1:ACC_W-1];
    sum      = sum_w[ACC_W-1:0];
    add_ovf  = !((&sum_hi) || !(|sum_hi));
    cnt_sat  = &cnt;
    cnt_next = cnt_sat ? cnt : cnt + LEN_W'(1);
    ovf_next = ovf | add_ovf | cnt_sat;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_FLUSH;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      ST_FLUSH:  if (flush_done)       state_next = ST_IDLE;
      ST_IDLE:   if (bus.in_valid)     state_next = ST_START;
      ST_START:                        state_next = ST_BUSY;
      ST_BUSY:   if (bus.mul_done)     state_next = last_r ? ST_OUTPUT : ST_IDLE;
      ST_OUTPUT: if (bus.out_ready)    state_next = ST_IDLE;
      default:                         state_next = ST_FLUSH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      flush_cnt   <= '0;
      last_r      <= 1'b0;
      acc         <= '0;
      cnt         <= '0;
      ovf         <= 1'b0;
      mul_st_r    <= 1'b0;
      mtp_r       <= '0;
      mtc_r       <= '0;
      out_valid_r <= 1'b0;
      out_sum_r   <= '0;
      out_count_r <= '0;
      out_ovf_r   <= 1'b0;
    end else begin
      mul_st_r <= (state_next == ST_START);
      if (state == ST_FLUSH && !flush_done)
        flush_cnt <= flush_cnt + FW'(1);
      if (state == ST_IDLE && bus.in_valid) begin
        mtp_r  <= bus.in_a;
        mtc_r  <= bus.in_b;
        last_r <= bus.in_last;
      end
      if (state == ST_BUSY && bus.mul_done) begin
        acc <= sum;
        cnt <= cnt_next;
        ovf <= ovf_next;
        if (last_r) begin
          out_sum_r   <= sum;
          out_count_r <= cnt_next;
          out_ovf_r   <= ovf_next;
          out_valid_r <= 1'b1;
        end
      end
      if (state == ST_OUTPUT && bus.out_ready) begin
        acc         <= '0;
        cnt         <= '0;
        ovf         <= 1'b0;
        out_valid_r <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = (state == ST_IDLE);
  assign bus.mul_st    = mul_st_r;
  assign bus.mul_mtp   = mtp_r;
  assign bus.mul_mtc   = mtc_r;
  assign bus.out_valid = out_valid_r;
  assign bus.out_sum   = out_sum_r;
  assign bus.out_count = out_count_r;
  assign bus.out_ovf   = out_ovf_r;

endmodule
